switch_debouncer: RTL and testbench
===================================

// Module: switch_debouncer
// PURPOSE
//  Multi-channel front end for raw mechanical inputs (encoder A/B, push button).
//  Synchronises each input to clk, filters contact bounce, and emits a clean level
//  plus one-cycle rise/fall strobes. Also detects a long hold on each channel.
//  Feeds the encoder counter / 7-segment logic directly downstream.
// PARAMETERS
//  CHANNELS        3           number of independent inputs
//  DEBOUNCE_CYCLES 50_000      cycles a new level must persist before acceptance (1 ms @ 50 MHz)
//  HOLD_CYCLES     25_000_000  cycles in active state before hold strobe (0.5 s @ 50 MHz)
//  IDLE_LEVEL      1'b1        released/idle level of inputs (pull-ups); active = ~IDLE_LEVEL
// PORTS
//  clk        in   1         single clock; all logic on posedge
//  rst_n      in   1         reset, asynchronous assert, active-low
//  sw_in      in   CHANNELS  raw asynchronous switch inputs
//  sw_out     out  CHANNELS  debounced level
//  sw_rise    out  CHANNELS  1-cycle strobe, sw_out went 0->1
//  sw_fall    out  CHANNELS  1-cycle strobe, sw_out went 1->0
//  sw_hold    out  CHANNELS  1-cycle strobe, active level held HOLD_CYCLES
//  sw_held    out  CHANNELS  level: hold reached, stays high until release
// BEHAVIOUR
//  Interface: one clock, clk; reset rst_n is asynchronous and active-low.
//  Reset: sync flops and sw_out = {CHANNELS{IDLE_LEVEL}}; rise/fall/hold/held = 0; counters = 0.
//  Sync: 2-flop synchroniser per channel; debounce logic sees only sync stage 2 (s).
//  Debounce counter (width $clog2(DEBOUNCE_CYCLES+1)), per channel:
//   - s == sw_out: counter cleared.
//   - s != sw_out: counter increments; on the cycle it equals DEBOUNCE_CYCLES-1,
//     next edge sets sw_out <= s, clears counter, asserts sw_rise or sw_fall for exactly 1 cycle.
//   - any glitch back to sw_out before terminal count clears counter (no partial credit).
//  Latency: stable input change -> sw_out change = 2 + DEBOUNCE_CYCLES cycles.
//  Strobes are registered and coincide with the first cycle of the new sw_out value.
//  Hold counter (width $clog2(HOLD_CYCLES+1)), per channel:
//   - counts while sw_out == ~IDLE_LEVEL and sw_held == 0; cleared whenever sw_out == IDLE_LEVEL.
//   - reaching HOLD_CYCLES-1: next edge pulses sw_hold 1 cycle, sets sw_held; counter stops (no wrap).
//   - release (sw_out returns to IDLE_LEVEL) clears sw_held same edge the fall/rise strobe fires.
//  Channels fully independent; simultaneous events on several channels all reported same cycle.
//  Reset mid-bounce or mid-hold: all state returns to reset values immediately; no strobe on
//   deassertion even if sw_in is then active (acceptance needs full debounce window again).
//  DEBOUNCE_CYCLES >= 2 and HOLD_CYCLES >= 2 required; elaboration error otherwise.
// STRUCTURE
//  Shared package ui_pkg: board clock constant CLK_HZ = 50_000_000 and derived default
//   DEBOUNCE_CYCLES / HOLD_CYCLES; no typedefs needed.
//  Sub-module debounce_channel (one input: sync, debounce counter, hold counter, strobes),
//   instantiated CHANNELS times in a generate loop; top level is wiring only.
// TESTING  (bench params: CHANNELS=3, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, IDLE_LEVEL=1)
//  Reset: rst_n=0 with sw_in=3'b000 -> sw_out=3'b111, all strobes 0; after release no strobe
//   until sw_in=0 held 6 cycles.
//  Clean press ch0: sw_in[0] 1->0 held -> sw_out[0] falls exactly 6 cycles later, sw_fall[0] 1 cycle.
//  Bounce: sw_in[0] toggles every 2 cycles for 20 cycles then settles 0 -> single sw_fall[0],
//   6 cycles after settling; no sw_rise.
//  Hold: ch2 held active 30 cycles -> sw_hold[2] one pulse 10 cycles after sw_fall[2], sw_held[2]
//   high until release; on release sw_rise[2] and sw_held[2]=0 same cycle.
//  Simultaneous: ch0 and ch1 switched same cycle -> strobes on both in same cycle.
//  Reset mid-operation: assert rst_n during debounce count 3 -> no strobe, sw_out back to 3'b111.

Source files
------------

// File: rtl/ui_pkg.sv
// Board-level constants for the user-input front end.
// Debounce and hold defaults are derived from the board clock.
package ui_pkg;
   localparam int CLK_HZ              = 50_000_000;
   localparam int DEBOUNCE_CYCLES_DEF = CLK_HZ / 1000;  // 1 ms
   localparam int HOLD_CYCLES_DEF     = CLK_HZ / 2;     // 0.5 s
endpackage

// File: rtl/debounce_channel.sv
// One switch input: 2-flop synchroniser, debounce filter with rise/fall strobes,
// and long-hold detection while the debounced level is active.
module debounce_channel
   import ui_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int   HOLD_CYCLES     = HOLD_CYCLES_DEF,
   parameter logic IDLE_LEVEL      = 1'b1
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_sw,
   output logic o_out,
   output logic o_rise,
   output logic o_fall,
   output logic o_hold,
   output logic o_held
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HW = $clog2(HOLD_CYCLES + 1);

   if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 2) begin : g_bad_params
      $error("debounce_channel: DEBOUNCE_CYCLES and HOLD_CYCLES must be >= 2");
   end

   logic          r_sync1, r_sync2, r_out;
   logic          r_rise, r_fall, r_hold, r_held;
   logic [DW-1:0] r_dcnt;
   logic [HW-1:0] r_hcnt;
   logic          w_accept;

   // New level has persisted for the full window; takes effect on this edge.
   assign w_accept = (r_sync2 != r_out) && (r_dcnt == DW'(DEBOUNCE_CYCLES - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1 <= IDLE_LEVEL;
         r_sync2 <= IDLE_LEVEL;
      end else begin
         r_sync1 <= i_sw;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_out  <= IDLE_LEVEL;
         r_dcnt <= '0;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_rise <= 1'b0;
         r_fall <= 1'b0;
         if (r_sync2 == r_out) begin
            r_dcnt <= '0;
         end else if (w_accept) begin
            r_out  <= r_sync2;
            r_dcnt <= '0;
            r_rise <= r_sync2;
            r_fall <= ~r_sync2;
         end else begin
            r_dcnt <= r_dcnt + 1'b1;
         end
      end
   end

   // A release clears held on the same edge the debounced level returns to idle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_hcnt <= '0;
         r_hold <= 1'b0;
         r_held <= 1'b0;
      end else begin
         r_hold <= 1'b0;
         if (r_out == IDLE_LEVEL || w_accept) begin
            r_hcnt <= '0;
            r_held <= 1'b0;
         end else if (!r_held) begin
            if (r_hcnt == HW'(HOLD_CYCLES - 1)) begin
               r_hold <= 1'b1;
               r_held <= 1'b1;
            end else begin
               r_hcnt <= r_hcnt + 1'b1;
            end
         end
      end
   end

   assign o_out  = r_out;
   assign o_rise = r_rise;
   assign o_fall = r_fall;
   assign o_hold = r_hold;
   assign o_held = r_held;
endmodule

// File: rtl/switch_debouncer.sv
// Multi-channel switch front end: one independent debounce_channel per input.
// Wiring only; all behaviour lives in the channel.
module switch_debouncer
   import ui_pkg::*;
#(
   parameter int   CHANNELS        = 3,
   parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int   HOLD_CYCLES     = HOLD_CYCLES_DEF,
   parameter logic IDLE_LEVEL      = 1'b1
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic [CHANNELS-1:0] i_sw_in,
   output logic [CHANNELS-1:0] o_sw_out,
   output logic [CHANNELS-1:0] o_sw_rise,
   output logic [CHANNELS-1:0] o_sw_fall,
   output logic [CHANNELS-1:0] o_sw_hold,
   output logic [CHANNELS-1:0] o_sw_held
);
   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .HOLD_CYCLES     (HOLD_CYCLES),
         .IDLE_LEVEL      (IDLE_LEVEL)
      ) u_ch (
         .i_clk   (i_clk),
         .i_rst_n (i_rst_n),
         .i_sw    (i_sw_in[g]),
         .o_out   (o_sw_out[g]),
         .o_rise  (o_sw_rise[g]),
         .o_fall  (o_sw_fall[g]),
         .o_hold  (o_sw_hold[g]),
         .o_held  (o_sw_held[g])
      );
   end
endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench for switch_debouncer: stimulus pushes expected strobe events,
// a negedge monitor pops and compares whenever any strobe is presented.
module tb_switch_debouncer;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] sw_in;
   logic [2:0] sw_out, sw_rise, sw_fall, sw_hold, sw_held;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      int         c;
      logic [2:0] rise, fall, hold, held, out;
   } ev_t;
   ev_t q[$];

   switch_debouncer #(
      .CHANNELS        (3),
      .DEBOUNCE_CYCLES (4),
      .HOLD_CYCLES     (10),
      .IDLE_LEVEL      (1'b1)
   ) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_sw_in   (sw_in),
      .o_sw_out  (sw_out),
      .o_sw_rise (sw_rise),
      .o_sw_fall (sw_fall),
      .o_sw_hold (sw_hold),
      .o_sw_held (sw_held)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic step(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic expect_ev(input int c, input logic [2:0] r, f, h, hd, o);
      ev_t e;
      e.c = c; e.rise = r; e.fall = f; e.hold = h; e.held = hd; e.out = o;
      q.push_back(e);
   endtask

   task automatic chk(input string name, input logic [14:0] got, input logic [14:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got out/rise/fall/hold/held=%b required %b", name, got, exp);
      end
   endtask

   // Monitor: missed events, unexpected strobes, and field-level comparison.
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].c < cyc) begin
         checks++;
         errors++;
         $display("FAIL missing_event: expected at cycle %0d, still absent at cycle %0d", q[0].c, cyc);
         void'(q.pop_front());
      end
      if ((sw_rise | sw_fall | sw_hold) != 3'b000) begin
         checks++;
         if (q.size() == 0 || q[0].c != cyc) begin
            errors++;
            $display("FAIL unexpected_event: cycle %0d rise=%b fall=%b hold=%b", cyc, sw_rise, sw_fall, sw_hold);
         end else begin
            ev_t e;
            e = q.pop_front();
            if ({sw_out, sw_rise, sw_fall, sw_hold, sw_held} !==
                {e.out, e.rise, e.fall, e.hold, e.held}) begin
               errors++;
               $display("FAIL event_c%0d: got out=%b rise=%b fall=%b hold=%b held=%b required out=%b rise=%b fall=%b hold=%b held=%b",
                        cyc, sw_out, sw_rise, sw_fall, sw_hold, sw_held,
                        e.out, e.rise, e.fall, e.hold, e.held);
            end
         end
      end
   end

   initial begin
      int n;
      rst_n = 1'b0;
      sw_in = 3'b000;

      // Reset with inputs active: outputs idle, no strobes.
      step(3);
      chk("reset_state", {sw_out, sw_rise, sw_fall, sw_hold, sw_held}, {3'b111, 12'b0});
      rst_n = 1'b1;
      n = cyc;
      expect_ev(n + 6, 3'b000, 3'b111, 3'b000, 3'b000, 3'b000);
      step(8);
      sw_in = 3'b111;
      n = cyc;
      expect_ev(n + 6, 3'b111, 3'b000, 3'b000, 3'b000, 3'b111);
      step(10);

      // Clean press / release on ch0.
      sw_in = 3'b110;
      n = cyc;
      expect_ev(n + 6, 3'b000, 3'b001, 3'b000, 3'b000, 3'b110);
      step(8);
      sw_in = 3'b111;
      n = cyc;
      expect_ev(n + 6, 3'b001, 3'b000, 3'b000, 3'b000, 3'b111);
      step(10);

      // Bounce on ch0: toggling every 2 cycles never earns acceptance.
      for (int i = 0; i < 10; i++) begin
         sw_in[0] = i[0];
         step(2);
      end
      sw_in[0] = 1'b0;
      n = cyc;
      expect_ev(n + 6, 3'b000, 3'b001, 3'b000, 3'b000, 3'b110);
      step(8);
      sw_in = 3'b111;
      n = cyc;
      expect_ev(n + 6, 3'b001, 3'b000, 3'b000, 3'b000, 3'b111);
      step(10);

      // Long hold on ch2.
      sw_in = 3'b011;
      n = cyc;
      expect_ev(n + 6,  3'b000, 3'b100, 3'b000, 3'b000, 3'b011);
      expect_ev(n + 16, 3'b000, 3'b000, 3'b100, 3'b100, 3'b011);
      expect_ev(n + 36, 3'b100, 3'b000, 3'b000, 3'b000, 3'b111);
      step(22);
      chk("held_level_mid", {sw_out, sw_rise, sw_fall, sw_hold, sw_held},
          {3'b011, 9'b0, 3'b100});
      step(8);
      sw_in = 3'b111;
      step(16);

      // Simultaneous ch0+ch1.
      sw_in = 3'b100;
      n = cyc;
      expect_ev(n + 6, 3'b000, 3'b011, 3'b000, 3'b000, 3'b100);
      step(8);
      sw_in = 3'b111;
      n = cyc;
      expect_ev(n + 6, 3'b011, 3'b000, 3'b000, 3'b000, 3'b111);
      step(10);

      // Reset while ch0 debounce counter is at 3.
      sw_in = 3'b110;
      step(5);
      rst_n = 1'b0;
      #1;
      chk("reset_mid_count", {sw_out, sw_rise, sw_fall, sw_hold, sw_held}, {3'b111, 12'b0});
      sw_in = 3'b111;
      step(2);
      rst_n = 1'b1;
      step(12);
      chk("after_mid_reset", {sw_out, sw_rise, sw_fall, sw_hold, sw_held}, {3'b111, 12'b0});

      step(4);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL queue_drained: got %0d pending events required 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
